// File: rtl/aura_mem_ctrl_pkg.sv
// Shared types for the AURA memory front-end: memory port types, ROB/tag-table
// entries and the read-stream FSM states.
package aura_mem_ctrl_pkg;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    localparam int unsigned LINE_BYTES = 8;

    // Slot index width covers ROB depths up to 8 entries.
    localparam int unsigned SLOT_W = 3;
    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [SLOT_W:0]   cnt_t;

    typedef struct packed {
        logic     filled;
        MEM_BLOCK data;
    } ROB_ENTRY;

    typedef struct packed {
        logic  valid;
        slot_t slot;
    } TAG_MAP;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } rd_state_e;

endpackage

// File: rtl/aura_mem_ctrl_if.sv
// Bundle of read-stream, store and memory-port signals around aura_mem_ctrl.
// slave = controller view, master = datapath/memory environment view.
interface aura_mem_ctrl_if #(
    parameter int unsigned LEN_W = 10
);
    import aura_mem_ctrl_pkg::*;

    logic             rd_start;
    ADDR              rd_base;
    logic [LEN_W-1:0] rd_lines;
    logic             rd_busy;
    logic             rd_data_valid;
    MEM_BLOCK         rd_data;
    logic             rd_data_last;
    logic             rd_data_ready;
    logic             wr_valid;
    ADDR              wr_addr;
    MEM_BLOCK         wr_data;
    logic             wr_ready;
    MEM_COMMAND       proc2mem_command;
    ADDR              proc2mem_addr;
    MEM_BLOCK         proc2mem_data;
    MEM_TAG           mem2proc_transaction_tag;
    MEM_BLOCK         mem2proc_data;
    MEM_TAG           mem2proc_data_tag;
    logic             err_tag;

    modport slave (
        input  rd_start, rd_base, rd_lines, rd_data_ready,
        input  wr_valid, wr_addr, wr_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output rd_busy, rd_data_valid, rd_data, rd_data_last, wr_ready,
        output proc2mem_command, proc2mem_addr, proc2mem_data, err_tag
    );

    modport master (
        output rd_start, rd_base, rd_lines, rd_data_ready,
        output wr_valid, wr_addr, wr_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  rd_busy, rd_data_valid, rd_data, rd_data_last, wr_ready,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, err_tag
    );

endinterface

// File: rtl/aura_rob.sv
// Reorder buffer: slots are allocated in order at load acceptance, filled out of
// order through the tag table, and drained in order from the head.
module aura_rob
    import aura_mem_ctrl_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 8
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     alloc,
    input  MEM_TAG   alloc_tag,
    input  MEM_TAG   ret_tag,
    input  MEM_BLOCK ret_data,
    input  logic     pop,
    output logic     head_filled,
    output MEM_BLOCK head_data,
    output logic     has_space,
    output logic     err_tag
);

    ROB_ENTRY rob_q [ROB_DEPTH];
    ROB_ENTRY rob_d [ROB_DEPTH];
    TAG_MAP   tag_q [16];
    TAG_MAP   tag_d [16];
    slot_t    head_q, head_d, tail_q, tail_d;
    cnt_t     count_q, count_d;
    logic     err_q, err_d;

    function automatic slot_t bump(input slot_t s);
        return (s == slot_t'(ROB_DEPTH - 1)) ? '0 : s + 1'b1;
    endfunction

    assign head_filled = rob_q[head_q].filled;
    assign head_data   = rob_q[head_q].data;
    // Uses the registered count, so a slot freed this cycle is reusable next cycle.
    assign has_space   = count_q < cnt_t'(ROB_DEPTH);
    assign err_tag     = err_q;

    // Next state: return fill, head pop and tail allocation in one cycle.
    always_comb begin
        rob_d   = rob_q;
        tag_d   = tag_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        if (ret_tag != '0) begin
            if (tag_q[ret_tag].valid) begin
                rob_d[tag_q[ret_tag].slot] = '{filled: 1'b1, data: ret_data};
                tag_d[ret_tag]             = '0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            rob_d[head_q].filled = 1'b0;
            head_d               = bump(head_q);
        end
        // Allocation after the clear so a tag returned and reissued this cycle stays mapped.
        if (alloc) begin
            tag_d[alloc_tag] = '{valid: 1'b1, slot: tail_q};
            tail_d           = bump(tail_q);
        end
        case ({alloc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rob_q   <= '{default: '0};
            tag_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rob_q   <= rob_d;
            tag_q   <= tag_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/aura_mem_ctrl.sv
// AURA memory front-end: read-stream issue FSM, store/load arbitration onto the
// single memory port, and in-order delivery through aura_rob.
module aura_mem_ctrl
    import aura_mem_ctrl_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned LEN_W     = 10
) (
    input logic            clock,
    input logic            reset,
    aura_mem_ctrl_if.slave bus
);

    rd_state_e        state_q, state_d;
    ADDR              next_addr_q, next_addr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] out_left_q, out_left_d;
    logic             prio_store_q, prio_store_d;
    logic             hold_q, hold_d, hold_store_q, hold_store_d;

    logic     load_req, store_req, grant_load, grant_store;
    logic     tag_ok, accepted, load_acc, pop;
    logic     has_space, head_filled;
    MEM_BLOCK head_data;

    assign load_req  = (state_q == StIssue) && has_space;
    assign store_req = bus.wr_valid;
    assign tag_ok    = bus.mem2proc_transaction_tag != '0;
    assign accepted  = (grant_store || grant_load) && tag_ok;
    assign load_acc  = grant_load && tag_ok;
    assign pop       = head_filled && bus.rd_data_ready;

    assign bus.wr_ready      = grant_store && tag_ok;
    assign bus.rd_busy       = state_q != StIdle;
    assign bus.rd_data_valid = head_filled;
    assign bus.rd_data       = head_data;
    assign bus.rd_data_last  = head_filled && (out_left_q == LEN_W'(1));

    // Arbitration: a rejected request keeps its grant so it is re-presented unchanged.
    always_comb begin
        grant_store = store_req && (!load_req || (hold_q ? hold_store_q : prio_store_q));
        grant_load  = load_req && !grant_store;
        bus.proc2mem_command = MEM_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (grant_store) begin
            bus.proc2mem_command = MEM_STORE;
            bus.proc2mem_addr    = bus.wr_addr;
            bus.proc2mem_data    = bus.wr_data;
        end else if (grant_load) begin
            bus.proc2mem_command = MEM_LOAD;
            bus.proc2mem_addr    = next_addr_q;
        end
        prio_store_d = accepted ? grant_load : prio_store_q;
        hold_d       = (grant_store || grant_load) && !tag_ok;
        hold_store_d = grant_store;
    end

    // Read FSM next state and stream counters.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        out_left_d  = pop ? out_left_q - 1'b1 : out_left_q;
        case (state_q)
            StIdle: begin
                if (bus.rd_start && bus.rd_lines != '0) begin
                    next_addr_d = bus.rd_base;
                    remaining_d = bus.rd_lines;
                    out_left_d  = bus.rd_lines;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (load_acc) begin
                    next_addr_d = next_addr_q + ADDR'(LINE_BYTES);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                // Final handoff empties the ROB: every line has been issued by now.
                if (pop && out_left_q == LEN_W'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            next_addr_q  <= '0;
            remaining_q  <= '0;
            out_left_q   <= '0;
            prio_store_q <= 1'b1;
            hold_q       <= 1'b0;
            hold_store_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            remaining_q  <= remaining_d;
            out_left_q   <= out_left_d;
            prio_store_q <= prio_store_d;
            hold_q       <= hold_d;
            hold_store_q <= hold_store_d;
        end
    end

    aura_rob #(
        .ROB_DEPTH (ROB_DEPTH)
    ) u_rob (
        .clock       (clock),
        .reset       (reset),
        .alloc       (load_acc),
        .alloc_tag   (bus.mem2proc_transaction_tag),
        .ret_tag     (bus.mem2proc_data_tag),
        .ret_data    (bus.mem2proc_data),
        .pop         (pop),
        .head_filled (head_filled),
        .head_data   (head_data),
        .has_space   (has_space),
        .err_tag     (bus.err_tag)
    );

endmodule

// File: tb/tb_aura_mem_ctrl.sv
// Directed bench for aura_mem_ctrl; the bench plays both datapath and memory.
module tb_aura_mem_ctrl;
    import aura_mem_ctrl_pkg::*;

    localparam ADDR Q_BASE = 32'h0000_1000;
    localparam ADDR K_BASE = 32'h0000_2000;
    localparam ADDR V_BASE = 32'h0000_3000;
    localparam ADDR O_BASE = 32'h0000_4000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    aura_mem_ctrl_if #(.LEN_W(10)) bus ();

    aura_mem_ctrl #(
        .ROB_DEPTH (8),
        .LEN_W     (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        MEM_TAG tag;
        ADDR    addr;
    } req_t;

    req_t       outq[$];
    ADDR        load_addrs[$];
    ADDR        pres_addrs[$];
    ADDR        store_addrs[$];
    MEM_COMMAND acc_cmds[$];
    MEM_BLOCK   got_data[$];
    logic       got_last[$];
    int         cyc_cnt;
    int         last_pop_cyc;
    int         n_wr_ready;

    function automatic MEM_BLOCK line_of(input ADDR a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic MEM_TAG free_tag();
        bit used;
        for (int t = 1; t < 16; t++) begin
            used = 1'b0;
            foreach (outq[i]) if (outq[i].tag == MEM_TAG'(t)) used = 1'b1;
            if (!used) return MEM_TAG'(t);
        end
        return '0;
    endfunction

    task automatic clear_logs();
        load_addrs.delete();
        pres_addrs.delete();
        store_addrs.delete();
        acc_cmds.delete();
        got_data.delete();
        got_last.delete();
        cyc_cnt      = 0;
        last_pop_cyc = -10;
        n_wr_ready   = 0;
    endtask

    // One clock cycle. ret_mode: 0 none, 1 oldest outstanding, 2 the tag in rtag.
    task automatic cycle(input bit accept, input int ret_mode, input MEM_TAG rtag,
                         input bit ready);
        req_t   r;
        MEM_TAG t;
        int     idx;
        bit     stored;
        stored = 1'b0;
        bus.rd_data_ready     = ready;
        bus.mem2proc_data_tag = '0;
        bus.mem2proc_data     = '0;
        if (ret_mode == 1 && outq.size() > 0) begin
            r = outq.pop_front();
            bus.mem2proc_data_tag = r.tag;
            bus.mem2proc_data     = line_of(r.addr);
        end else if (ret_mode == 2) begin
            idx = -1;
            foreach (outq[i]) if (outq[i].tag == rtag) idx = i;
            if (idx >= 0) begin
                r = outq[idx];
                outq.delete(idx);
                bus.mem2proc_data_tag = r.tag;
                bus.mem2proc_data     = line_of(r.addr);
            end
        end
        #1;
        bus.mem2proc_transaction_tag = '0;
        if (bus.proc2mem_command == MEM_LOAD) pres_addrs.push_back(bus.proc2mem_addr);
        if (accept && bus.proc2mem_command != MEM_NONE) begin
            t = free_tag();
            bus.mem2proc_transaction_tag = t;
            acc_cmds.push_back(bus.proc2mem_command);
            if (bus.proc2mem_command == MEM_LOAD) begin
                load_addrs.push_back(bus.proc2mem_addr);
                outq.push_back('{tag: t, addr: bus.proc2mem_addr});
            end else begin
                store_addrs.push_back(bus.proc2mem_addr);
            end
        end
        #1;
        if (bus.rd_data_valid && ready) begin
            got_data.push_back(bus.rd_data);
            got_last.push_back(bus.rd_data_last);
            last_pop_cyc = cyc_cnt;
        end
        if (bus.wr_ready) begin
            n_wr_ready++;
            stored = 1'b1;
        end
        @(posedge clock);
        #1;
        bus.mem2proc_transaction_tag = '0;
        bus.mem2proc_data_tag        = '0;
        if (stored) begin
            bus.wr_addr = bus.wr_addr + 32'd8;
            bus.wr_data = line_of(bus.wr_addr);
        end
        cyc_cnt++;
    endtask

    task automatic start(input ADDR base, input logic [9:0] lines);
        bus.rd_start = 1'b1;
        bus.rd_base  = base;
        bus.rd_lines = lines;
        cycle(1'b0, 0, '0, 1'b0);
        bus.rd_start = 1'b0;
    endtask

    task automatic drain_stream(input int max_cyc);
        int n;
        n = 0;
        while (bus.rd_busy && n < max_cyc) begin
            cycle(1'b1, 1, '0, 1'b1);
            n++;
        end
        check("stream_done_busy", bus.rd_busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rd_start = 1'b0;
        bus.rd_base = '0;
        bus.rd_lines = '0;
        bus.rd_data_ready = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.mem2proc_transaction_tag = '0;
        bus.mem2proc_data = '0;
        bus.mem2proc_data_tag = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_busy", bus.rd_busy, 1'b0);
        check("rst_valid", bus.rd_data_valid, 1'b0);
        check("rst_data", bus.rd_data, 64'h0);
        check("rst_cmd", bus.proc2mem_command, MEM_NONE);
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_err", bus.err_tag, 1'b0);

        // rd_lines = 0 is a no-op
        clear_logs();
        start(Q_BASE, 10'd0);
        check("zero_lines_busy", bus.rd_busy, 1'b0);

        // In-order stream of 4 lines
        outq.delete();
        clear_logs();
        start(Q_BASE, 10'd4);
        check("inord_busy", bus.rd_busy, 1'b1);
        drain_stream(100);
        check("inord_nloads", load_addrs.size(), 4);
        check("inord_nlines", got_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("inord_addr", load_addrs[i], Q_BASE + ADDR'(8 * i));
            check("inord_data", got_data[i], line_of(Q_BASE + ADDR'(8 * i)));
            check("inord_last", got_last[i], (i == 3) ? 1'b1 : 1'b0);
        end
        check("inord_busy_drop", cyc_cnt, last_pop_cyc + 1);

        // Out-of-order returns 3, 1, 2
        do_reset();
        outq.delete();
        clear_logs();
        start(K_BASE, 10'd3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, '0, 1'b1);
        check("ooo_nloads", load_addrs.size(), 3);
        cycle(1'b0, 2, 4'd3, 1'b1);
        check("ooo_no_valid_t3", bus.rd_data_valid, 1'b0);
        cycle(1'b0, 2, 4'd1, 1'b1);
        check("ooo_no_pop_yet", got_data.size(), 0);
        check("ooo_valid_t1", bus.rd_data_valid, 1'b1);
        cycle(1'b0, 2, 4'd2, 1'b1);
        drain_stream(50);
        check("ooo_nlines", got_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("ooo_data", got_data[i], line_of(K_BASE + ADDR'(8 * i)));
        end
        check("ooo_last", got_last[2], 1'b1);
        check("ooo_err", bus.err_tag, 1'b0);

        // ROB full with consumer stalled
        do_reset();
        outq.delete();
        clear_logs();
        start(V_BASE, 10'd20);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1, '0, 1'b0);
        check("full_nloads", load_addrs.size(), 8);
        check("full_cmd_none", bus.proc2mem_command, MEM_NONE);
        check("full_no_pop", got_data.size(), 0);
        check("full_head_valid", bus.rd_data_valid, 1'b1);
        drain_stream(400);
        check("full_total_loads", load_addrs.size(), 20);
        check("full_nlines", got_data.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < got_data.size())
                check("full_data", got_data[i], line_of(V_BASE + ADDR'(8 * i)));
        end
        if (got_last.size() == 20) begin
            check("full_last19", got_last[19], 1'b1);
            check("full_last18", got_last[18], 1'b0);
        end

        // Rejection: tag = 0 for three cycles
        do_reset();
        outq.delete();
        clear_logs();
        start(Q_BASE, 10'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, '0, 1'b1);
        cycle(1'b1, 0, '0, 1'b1);
        check("rej_presented", pres_addrs.size(), 4);
        foreach (pres_addrs[i]) check("rej_same_addr", pres_addrs[i], Q_BASE);
        check("rej_nloads", load_addrs.size(), 1);
        drain_stream(50);
        check("rej_addr1", load_addrs[1], Q_BASE + 32'd8);
        check("rej_nlines", got_data.size(), 2);

        // Store/load alternation
        do_reset();
        outq.delete();
        clear_logs();
        start(Q_BASE, 10'd3);
        bus.wr_addr  = O_BASE;
        bus.wr_data  = line_of(O_BASE);
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1, '0, 1'b1);
        bus.wr_valid = 1'b0;
        check("mix_nacc", acc_cmds.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_cmds.size())
                check("mix_cmd", acc_cmds[i], (i % 2 == 0) ? MEM_STORE : MEM_LOAD);
        end
        check("mix_wr_ready", n_wr_ready, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < store_addrs.size())
                check("mix_store_addr", store_addrs[i], O_BASE + ADDR'(8 * i));
        end
        drain_stream(50);
        check("mix_nlines", got_data.size(), 3);

        // Reset with 5 loads outstanding
        do_reset();
        outq.delete();
        clear_logs();
        start(K_BASE, 10'd8);
        for (int i = 0; i < 5; i++) cycle(1'b1, 0, '0, 1'b1);
        check("midrst_outstanding", outq.size(), 5);
        reset = 1'b1;
        #1;
        check("midrst_busy", bus.rd_busy, 1'b0);
        check("midrst_cmd", bus.proc2mem_command, MEM_NONE);
        check("midrst_valid", bus.rd_data_valid, 1'b0);
        check("midrst_err", bus.err_tag, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1, '0, 1'b1);
        check("midrst_dropped", got_data.size(), 0);
        check("midrst_valid_after", bus.rd_data_valid, 1'b0);
        check("midrst_err_set", bus.err_tag, 1'b1);
        clear_logs();
        start(Q_BASE, 10'd2);
        drain_stream(50);
        check("post_nlines", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("post_data1", got_data[1], line_of(Q_BASE + 32'd8));
            check("post_last", got_last[1], 1'b1);
        end
        check("post_err_sticky", bus.err_tag, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aura_mem_ctrl.md
Name: aura_mem_ctrl

Overview:
- Memory front-end of the AURA accelerator. Sits between the AURA compute datapath (Q/K/V tile loaders, O writer) and the unified `mem` model.
- Converts a "read N lines from base" command into tagged MEM_LOAD requests and reorders out-of-order tagged returns into an in-order valid/ready stream.
- Arbitrates O write-back stores onto the same single memory port.

Parameters:
- ROB_DEPTH, 8, reorder-buffer entries and the maximum number of outstanding loads (power of 2, ≤15).
- LEN_W, 10, width of the line-count field (up to 512 lines, one full Q/K/V/O region).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_start  in  1  single-cycle pulse that begins a read stream
- rd_base  in  ADDR  byte address of the first line (8-byte aligned)
- rd_lines  in  LEN_W  number of 64-bit lines to read
- rd_busy  out  1  read stream in progress
- rd_data_valid  out  1  rd_data holds the next in-order line
- rd_data  out  MEM_BLOCK  returned line
- rd_data_last  out  1  rd_data is the final line of the stream
- rd_data_ready  in  1  consumer accepts rd_data
- wr_valid  in  1  store request pending
- wr_addr  in  ADDR  store byte address
- wr_data  in  MEM_BLOCK  store data
- wr_ready  out  1  store accepted this cycle
- proc2mem_command  out  MEM_COMMAND  MEM_NONE / MEM_LOAD / MEM_STORE
- proc2mem_addr  out  ADDR  request address
- proc2mem_data  out  MEM_BLOCK  store data
- mem2proc_transaction_tag  in  MEM_TAG  nonzero = request accepted this cycle
- mem2proc_data  in  MEM_BLOCK  returned load data
- mem2proc_data_tag  in  MEM_TAG  nonzero = mem2proc_data is valid for this tag
- err_tag  out  1  sticky: a return arrived with an unmapped tag

Behaviour:
- Reset values: all outputs 0, proc2mem_command = MEM_NONE, FSM = IDLE, tag table invalid, ROB empty, err_tag = 0.
- Port protocol:
  - A request is accepted iff the command ≠ MEM_NONE and mem2proc_transaction_tag ≠ 0 in the same cycle.
  - If the request is rejected (tag = 0), the identical request is re-presented the next cycle.
  - Stores never produce a data return.
- Read FSM states:
  - IDLE: on rd_start with rd_lines ≠ 0, latch base and count, go to ISSUE. rd_start with rd_lines = 0 is a no-op.
  - ISSUE: present MEM_LOAD at next_addr when ROB occupancy (allocated slots) < ROB_DEPTH. On acceptance:
    - write tag_table[tag] = {valid, slot};
    - allocate the tail slot, tail++, next_addr += 8, remaining--.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until the ROB is empty and the last line has been handed off, then go to IDLE.
  - rd_busy = (state ≠ IDLE). rd_start is ignored while busy.
- Return path: when mem2proc_data_tag ≠ 0 and tag_table[tag].valid:
  - store the data into that slot and mark the slot filled;
  - clear the table entry.
  - If the table entry is invalid, drop the data and set err_tag.
- Output:
  - rd_data_valid = head slot filled. rd_data comes from the head slot.
  - rd_data_last asserts when this is the final line of the stream.
  - Handoff occurs on valid & ready; the head slot frees and the head advances.
  - The output is combinational from the ROB registers.
- Arbitration:
  - When both a store and a load are pending, alternate round-robin, starting with the store after reset.
  - Loads blocked by a full ROB do not block stores.
  - wr_ready = the store was presented and accepted this cycle.
- Simultaneous events (all handled in one cycle, no interference):
  - a return for tag A together with acceptance of a new load;
  - a head pop together with new allocation: a slot freed this cycle is reusable next cycle only;
  - a return into the head slot together with ready: the data is visible the next cycle.
- Wrap-around: head and tail are log2(ROB_DEPTH)-bit counters. A separate occupancy count distinguishes full from empty.
- Reset mid-stream: all state clears immediately. Late returns after reset hit invalid table entries, are dropped, and set err_tag.

Decomposition:
- The aura_pkg package gains:
  - the ROB_ENTRY typedef {filled, MEM_BLOCK data};
  - the TAG_MAP typedef {valid, slot index};
  - a LINE_BYTES = 8 constant.
- MEM_COMMAND, MEM_TAG, MEM_BLOCK and ADDR are reused from sys_defs.
- One sub-module: aura_rob (tag-indexed fill, in-order drain).

Test Plan:
- In-order stream: rd_base = Q_BASE, rd_lines = 4, memory returns tags in order.
  - Expect 4 loads at Q_BASE, +8, +16, +24.
  - rd_data matches the memory contents in order; rd_data_last only on the 4th line.
  - rd_busy drops the cycle after the final handoff.
- Out-of-order returns: issue 3 loads (tags 1, 2, 3) and return them 3, 1, 2.
  - Output order is line0, line1, line2.
  - No rd_data_valid before tag 1 returns.
- Backpressure / full: ROB_DEPTH = 8, rd_lines = 20, rd_data_ready held 0.
  - Exactly 8 loads issue, then MEM_NONE.
  - Raise ready: issue resumes one load per freed slot; all 20 lines arrive in order.
- Rejection: hold mem2proc_transaction_tag = 0 for 3 cycles on the first load.
  - The same address is presented 4 times; it is accepted on the 4th.
  - next_addr does not advance early.
- Store/load mix: wr_valid continuously with O_BASE addresses during a read stream.
  - proc2mem_command alternates STORE / LOAD.
  - wr_ready pulses once per accepted store.
- Reset mid-stream: assert reset with 5 loads outstanding, then deliver their returns.
  - All outputs return to 0 and the returned data is dropped.
  - err_tag = 1; a subsequent rd_start works normally.
